// File: rtl/serial_to_parallel_pkg.sv
// Shared constants and state encoding for the serial link lanes.
// The parallel-to-serial transmit lane idles with the same COM symbol.
package serial_to_parallel_pkg;

  localparam logic [7:0] COM_SYM = 8'hBC;
  localparam int         CNT_W   = 3;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    COUNT   = 2'd1,
    ALIGNED = 2'd2
  } state_t;

endpackage

// File: rtl/s2p_shift_window.sv
// Serial shift register exposing the byte that completes on this edge.
// Only the low 7 stored bits ever reach the window, so the MSB is not kept.
module s2p_shift_window #(
  parameter int                 DATA_W = 8,
  parameter logic [DATA_W-1:0] SYM    = 8'hBC
) (
  input  logic              clk_8f,
  input  logic              reset,
  input  logic              data_in,
  output logic [DATA_W-1:0] win,
  output logic              is_com
);

  logic [DATA_W-2:0] sr;

  assign win    = {sr, data_in};
  assign is_com = (win == SYM);

  always_ff @(posedge clk_8f) begin
    if (reset) sr <= '0;
    else       sr <= win[DATA_W-2:0];
  end

endmodule

// File: rtl/serial_to_parallel_struct.sv
// Netlist-style twin of serial_to_parallel: explicit next-state equations
// feeding one flat register bank, ports identical to the behavioural top.
module serial_to_parallel_struct
  import serial_to_parallel_pkg::*;
#(
  parameter int                 DATA_W   = 8,
  parameter logic [DATA_W-1:0] COM      = COM_SYM,
  parameter int                 COM_LOCK = 4
) (
  input  logic              clk_8f,
  input  logic              reset,
  input  logic              data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              byte_strobe,
  output logic              active
);

  localparam logic [7:0] LOCK_N = 8'(COM_LOCK);
  localparam logic       LOCK_1 = (LOCK_N == 8'd1);

  logic [DATA_W-1:0] win;
  logic              hit;
  state_t            state, state_nx;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nx;
  logic [7:0]        com_cnt, com_cnt_nx;
  logic [DATA_W-1:0] data_nx;
  logic              valid_nx, strobe_nx, active_nx;
  logic              s_search, s_count, s_aligned, last;
  logic              search_hit, cnt_eval, al_eval, lock_done;
  logic              to_aligned, to_count, to_search, cnt_inc;

  s2p_shift_window #(.DATA_W(DATA_W), .SYM(COM)) u_win (
    .clk_8f (clk_8f),
    .reset  (reset),
    .data_in(data_in),
    .win    (win),
    .is_com (hit)
  );

  assign s_search   = (state == SEARCH);
  assign s_count    = (state == COUNT);
  assign s_aligned  = (state == ALIGNED);
  assign last       = (bit_cnt == '1);
  assign lock_done  = ((com_cnt + 8'd1) == LOCK_N);

  assign search_hit = s_search & hit;
  assign cnt_eval   = s_count & last;
  assign al_eval    = s_aligned & last;

  assign to_aligned = (search_hit & LOCK_1)
                    | (cnt_eval & hit & lock_done);
  assign to_count   = search_hit & ~LOCK_1;
  assign to_search  = cnt_eval & ~hit;
  assign cnt_inc    = cnt_eval & hit & ~lock_done;

  assign state_nx   = to_aligned ? ALIGNED :
                      to_count   ? COUNT   :
                      to_search  ? SEARCH  : state;
  assign bit_cnt_nx = s_search ? '0 : bit_cnt + 1'b1;
  assign com_cnt_nx = to_count  ? 8'd1 :
                      to_search ? 8'd0 :
                      cnt_inc   ? com_cnt + 8'd1 : com_cnt;
  assign active_nx  = active | to_aligned;
  assign strobe_nx  = al_eval;
  assign valid_nx   = al_eval ? ~hit : valid_out;
  assign data_nx    = (al_eval & ~hit) ? win : data_out;

  always_ff @(posedge clk_8f) begin
    if (reset) begin
      state       <= SEARCH;
      bit_cnt     <= '0;
      com_cnt     <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
      active      <= 1'b0;
    end else begin
      state       <= state_nx;
      bit_cnt     <= bit_cnt_nx;
      com_cnt     <= com_cnt_nx;
      data_out    <= data_nx;
      valid_out   <= valid_nx;
      byte_strobe <= strobe_nx;
      active      <= active_nx;
    end
  end

endmodule

// File: rtl/serial_to_parallel.sv
// Receive lane: COM-hunting byte aligner and deserializer, MSB first.
// Once ALIGNED it stays there until reset; COM bytes read as idle.
module serial_to_parallel
  import serial_to_parallel_pkg::*;
#(
  parameter int                 DATA_W   = 8,
  parameter logic [DATA_W-1:0] COM      = COM_SYM,
  parameter int                 COM_LOCK = 4
) (
  input  logic              clk_8f,
  input  logic              reset,
  input  logic              data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              byte_strobe,
  output logic              active
);

  localparam logic [7:0] LOCK_N = 8'(COM_LOCK);

  logic [DATA_W-1:0] win;
  logic              is_com;
  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [7:0]        com_cnt;

  s2p_shift_window #(.DATA_W(DATA_W), .SYM(COM)) u_win (
    .clk_8f (clk_8f),
    .reset  (reset),
    .data_in(data_in),
    .win    (win),
    .is_com (is_com)
  );

  always_ff @(posedge clk_8f) begin
    if (reset) begin
      state       <= SEARCH;
      bit_cnt     <= '0;
      com_cnt     <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
      active      <= 1'b0;
    end else begin
      byte_strobe <= 1'b0;
      case (state)
        SEARCH: begin
          bit_cnt <= '0;
          if (is_com) begin
            if (LOCK_N == 8'd1) begin
              state  <= ALIGNED;
              active <= 1'b1;
            end else begin
              state   <= COUNT;
              com_cnt <= 8'd1;
            end
          end
        end
        COUNT: begin
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == '1) begin
            if (!is_com) begin
              state   <= SEARCH;
              com_cnt <= 8'd0;
            end else if (com_cnt + 8'd1 == LOCK_N) begin
              state  <= ALIGNED;
              active <= 1'b1;
            end else begin
              com_cnt <= com_cnt + 8'd1;
            end
          end
        end
        ALIGNED: begin
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == '1) begin
            byte_strobe <= 1'b1;
            valid_out   <= !is_com;
            if (!is_com) data_out <= win;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule
